// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: line/word vectors and the types used by
// the I/D-cache to main-memory arbiter.
package lc3b_types;

  localparam int LC3B_WORD_WIDTH = 16;
  localparam int LC3B_LINE_WIDTH = 128;

  typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_c_line;
  typedef logic [LC3B_WORD_WIDTH-1:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    TURN
  } lc3b_arb_state;

  typedef enum logic {
    ARB_I,
    ARB_D
  } lc3b_arb_src;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one Wishbone memory port between the split L1
// I-cache and D-cache; one line transaction per grant, then a turnaround cycle.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  i_stb,
  input  logic                  i_cyc,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_adr,
  input  logic [LINE_WIDTH-1:0] i_dat_m,
  output logic [LINE_WIDTH-1:0] i_dat_s,
  output logic                  i_ack,

  input  logic                  d_stb,
  input  logic                  d_cyc,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_adr,
  input  logic [LINE_WIDTH-1:0] d_dat_m,
  output logic [LINE_WIDTH-1:0] d_dat_s,
  output logic                  d_ack,

  output logic                  mem_stb,
  output logic                  mem_cyc,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic [LINE_WIDTH-1:0] mem_dat_m,
  input  logic [LINE_WIDTH-1:0] mem_dat_s,
  input  logic                  mem_ack
);

  lc3b_arb_state state, state_next;
  lc3b_arb_src   last_grant, last_grant_next;

  logic i_req;
  logic d_req;

  assign i_req = i_stb & i_cyc;
  assign d_req = d_stb & d_cyc;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ARB_D;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    mem_stb         = 1'b0;
    mem_cyc         = 1'b0;
    mem_we          = 1'b0;
    mem_adr         = '0;
    mem_dat_m       = '0;
    i_dat_s         = '0;
    i_ack           = 1'b0;
    d_dat_s         = '0;
    d_ack           = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          state_next = (last_grant == ARB_I) ? GRANT_D : GRANT_I;
        end else if (i_req) begin
          state_next = GRANT_I;
        end else if (d_req) begin
          state_next = GRANT_D;
        end
      end

      // Grant is held until mem_ack even if the owner drops its strobe.
      GRANT_I: begin
        mem_stb   = i_stb;
        mem_cyc   = i_cyc;
        mem_we    = i_we;
        mem_adr   = i_adr;
        mem_dat_m = i_dat_m;
        i_dat_s   = mem_dat_s;
        i_ack     = mem_ack;
        if (mem_ack) begin
          last_grant_next = ARB_I;
          state_next      = TURN;
        end
      end

      GRANT_D: begin
        mem_stb   = d_stb;
        mem_cyc   = d_cyc;
        mem_we    = d_we;
        mem_adr   = d_adr;
        mem_dat_m = d_dat_m;
        d_dat_s   = mem_dat_s;
        d_ack     = mem_ack;
        if (mem_ack) begin
          last_grant_next = ARB_D;
          state_next      = TURN;
        end
      end

      // Quiet cycle so the served cache can drop its now-stale strobe.
      TURN: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single Wishbone port to physical memory between the instruction cache and the data cache (split L1).
- Each cache's memory-side Wishbone master connects to one slave port here; the arbiter's master port drives main memory.
- Round-robin grant per 128-bit line transaction. The grant is held until memory ACKs, followed by one turnaround cycle.

Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b address).
- LINE_WIDTH, 128, cache line / memory data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_stb  in  1  I-cache request strobe.
- i_cyc  in  1  I-cache bus cycle.
- i_we  in  1  I-cache write enable (normally 0).
- i_adr  in  ADDR_WIDTH  I-cache line address.
- i_dat_m  in  LINE_WIDTH  I-cache write data.
- i_dat_s  out  LINE_WIDTH  read data to I-cache.
- i_ack  out  1  transaction complete to I-cache.
- d_stb, d_cyc, d_we, d_adr, d_dat_m  in  same widths  D-cache request, as for the I-cache.
- d_dat_s  out  LINE_WIDTH  read data to D-cache.
- d_ack  out  1  transaction complete to D-cache.
- mem_stb, mem_cyc, mem_we  out  1 each  to memory.
- mem_adr  out  ADDR_WIDTH  to memory.
- mem_dat_m  out  LINE_WIDTH  write data to memory.
- mem_dat_s  in  LINE_WIDTH  read data from memory.
- mem_ack  in  1  memory done.

Behaviour:
- Clocking: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Request definition: a requester is requesting when stb & cyc.
- States: IDLE, GRANT_I, GRANT_D, TURN.
- Reset (any state, asynchronous):
  - state=IDLE, last_grant=D, so the I-cache wins the first tie.
  - mem_stb=mem_cyc=mem_we=0, mem_adr=0, mem_dat_m=0.
  - i_ack=d_ack=0.
- A reset asserted mid-transaction abandons it. No ACK is produced for the abandoned transaction.
- IDLE transitions:
  - Only I requesting -> GRANT_I.
  - Only D requesting -> GRANT_D.
  - Both requesting -> grant the one not equal to last_grant.
  - Neither requesting -> stay in IDLE.
  - Grant is registered: a request sampled at edge n drives mem_stb from cycle n+1.
- GRANT_x:
  - mem_stb/cyc/we/adr/dat_m are combinationally muxed from requester x.
  - x_dat_s = mem_dat_s.
  - x_ack = mem_ack, combinational pass-through in the same cycle.
  - The other requester sees ack=0. Its dat_s is 0.
  - On mem_ack=1: last_grant<=x, go to TURN.
  - A requester dropping stb while granted (protocol violation) still holds the grant until mem_ack.
- TURN:
  - One cycle. All mem outputs are 0 and no acks are asserted.
  - Lets the served cache deassert stb, so a stale strobe is never re-granted.
  - Always returns to IDLE.
- Minimum added latency per transaction is 2 cycles: 1 grant cycle plus 1 turnaround.
- Fairness: with both caches requesting continuously, grants alternate I, D, I, D. Neither waits more than one foreign transaction.
- mem_dat_s is passed only to the granted side. The non-granted side's dat_s and ack are 0.
- No buffering: the arbiter stores no data and adds no pipeline registers on the data path.

Decomposition:
- lc3b_types package:
  - lc3b_c_line (LINE_WIDTH vector), already present.
  - lc3b_word for addresses.
  - New enum lc3b_arb_state {IDLE, GRANT_I, GRANT_D, TURN}.
  - New enum lc3b_arb_src {ARB_I, ARB_D} for last_grant.
- No sub-module needed; the mux is inline.

Test Plan:
- Reset then I-only read at 16'h0040, memory ACKs after 3 cycles -> mem_adr=16'h0040 with mem_we=0 from cycle+1; i_ack pulses in the same cycle as mem_ack; i_dat_s=mem_dat_s; d_ack stays 0.
- D-only write at 16'h1230 with dat_m=128'hA5..A5 -> mem_we=1, mem_dat_m=A5 pattern; d_ack on mem_ack; TURN cycle shows mem_stb=0.
- Simultaneous I and D requests right after reset -> I served first, then D; exactly one TURN cycle between the two grants.
- Both caches request continuously for 6 transactions -> grant order I,D,I,D,I,D; no back-to-back grants to the same side.
- D granted and waiting for ACK, I raises stb -> mem_adr stays the D address until mem_ack; I is granted after TURN.
- rst_n pulled low mid-GRANT_D -> all mem outputs 0 immediately, no d_ack, state IDLE; after release, a tie is granted to I.
